// File: rtl/aes_pkg.sv
// Shared definitions for the AES round controller: key-length codes,
// round counts, FSM state encoding and default widths.
package aes_pkg;

  localparam int unsigned KlenWDefault   = 2;
  localparam int unsigned CntSizeDefault = 4;

  // Key-length select encodings
  localparam int unsigned KeyLen128     = 0;
  localparam int unsigned KeyLen192     = 1;
  localparam int unsigned KeyLen256     = 2;
  localparam int unsigned KeyLenIllegal = 3;

  // Number of rounds per key length
  localparam int unsigned NrAes128 = 10;
  localparam int unsigned NrAes192 = 12;
  localparam int unsigned NrAes256 = 14;

  typedef enum logic [2:0] {
    StIdle,
    StKeyWait,
    StInit,
    StRound,
    StFinal,
    StDone
  } round_state_e;

  // Round count for a key-length code; 0 marks an illegal code.
  function automatic int unsigned nr_for_klen(input int unsigned klen);
    int unsigned nr;
    case (klen)
      KeyLen128:     nr = NrAes128;
      KeyLen192:     nr = NrAes192;
      KeyLen256:     nr = NrAes256;
      KeyLenIllegal: nr = 0;
      default:       nr = 0;
    endcase
    return nr;
  endfunction

endpackage

// File: rtl/aes_round_cnt.sv
// Round-index counter: synchronous clear, load and enable, with a
// terminal-count flag against a runtime limit. Saturates instead of wrapping.
module aes_round_cnt
  import aes_pkg::*;
#(
  parameter int unsigned CNT_SIZE = CntSizeDefault
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_i,
  input  logic                load_i,
  input  logic [CNT_SIZE-1:0] load_val_i,
  input  logic                en_i,
  input  logic [CNT_SIZE-1:0] limit_i,
  output logic [CNT_SIZE-1:0] cnt_o,
  output logic                tc_o
);

  logic [CNT_SIZE-1:0] cnt_q, cnt_d;

  // Next count: clear has priority over load, load over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != {CNT_SIZE{1'b1}})) begin
      cnt_d = cnt_q + CNT_SIZE'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == limit_i);

endmodule

// File: rtl/aes_round_ctrl.sv
// AES encryption round controller: sequences key wait, initial key add,
// Nr-1 full rounds and a final round, then holds the result until accepted.
// Every output is a flop driven from next-state logic.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned CNT_SIZE = CntSizeDefault,
  parameter int unsigned KLEN_W   = KlenWDefault
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_start,
  input  logic [KLEN_W-1:0]   i_key_len,
  input  logic                i_ks_ready,
  input  logic                i_out_ready,
  output logic                o_busy,
  output logic                o_ks_req,
  output logic                o_load,
  output logic                o_round_en,
  output logic                o_final,
  output logic [CNT_SIZE-1:0] o_round_idx,
  output logic                o_valid,
  output logic                o_err
);

  round_state_e        state_q, state_d;
  logic [CNT_SIZE-1:0] nr_q, nr_d;
  logic [CNT_SIZE-1:0] cnt_limit;
  logic                cnt_clr, cnt_load, cnt_en, cnt_tc;
  logic                err_d;
  int unsigned         nr_sel;

  assign nr_sel    = nr_for_klen(32'(i_key_len));
  // Last full round is Nr-1; the final round follows it.
  assign cnt_limit = nr_q - CNT_SIZE'(1);

  aes_round_cnt #(
    .CNT_SIZE (CNT_SIZE)
  ) u_round_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (cnt_clr),
    .load_i     (cnt_load),
    .load_val_i (CNT_SIZE'(1)),
    .en_i       (cnt_en),
    .limit_i    (cnt_limit),
    .cnt_o      (o_round_idx),
    .tc_o       (cnt_tc)
  );

  // Next-state, round-count latch and counter control.
  always_comb begin
    state_d = state_q;
    nr_d    = nr_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          if (nr_sel != 0) begin
            nr_d    = CNT_SIZE'(nr_sel);
            state_d = StKeyWait;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StKeyWait: begin
        if (i_ks_ready) state_d = StInit;
      end
      StInit: begin
        state_d = StRound;
      end
      StRound: begin
        if (cnt_tc) state_d = StFinal;
      end
      StFinal: begin
        state_d = StDone;
      end
      StDone: begin
        if (i_out_ready) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Index starts at 1 on the first round and is held at 0 outside rounds.
    cnt_load = (state_q == StInit);
    cnt_en   = (state_q == StRound);
    cnt_clr  = !((state_d == StRound) || (state_d == StFinal));
  end

  // State and latched round count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      nr_q    <= '0;
    end else begin
      state_q <= state_d;
      nr_q    <= nr_d;
    end
  end

  // Registered outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_busy     <= 1'b0;
      o_ks_req   <= 1'b0;
      o_load     <= 1'b0;
      o_round_en <= 1'b0;
      o_final    <= 1'b0;
      o_valid    <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      o_busy     <= (state_d != StIdle);
      o_ks_req   <= (state_d == StKeyWait);
      o_load     <= (state_d == StInit);
      o_round_en <= (state_d == StRound) || (state_d == StFinal);
      o_final    <= (state_d == StFinal);
      o_valid    <= (state_d == StDone);
      o_err      <= err_d;
    end
  end

endmodule
